// File: rtl/helios_decoder_dispatcher.sv
// Round-robin frame dispatcher sharing NUM_CORES decoder cores; results return in dispatch order.
// Define DISPATCHER_STATS_EN to add the frames_dispatched / frames_returned counters.
module helios_decoder_dispatcher #(
  parameter int NUM_CORES    = 2,
  parameter int FRAME_BYTES  = 4,
  parameter int RESULT_BYTES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [8*NUM_CORES-1:0] core_in_data,
  output logic [NUM_CORES-1:0]   core_in_valid,
  input  logic [NUM_CORES-1:0]   core_in_ready,
  input  logic [8*NUM_CORES-1:0] core_out_data,
  input  logic [NUM_CORES-1:0]   core_out_valid,
  output logic [NUM_CORES-1:0]   core_out_ready,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_CORES-1:0]   core_busy
`ifdef DISPATCHER_STATS_EN
  ,
  output logic [15:0]            frames_dispatched,
  output logic [15:0]            frames_returned
`endif
);

  localparam int CORE_W = $clog2(NUM_CORES);
  localparam int DCNT_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int CCNT_W = (RESULT_BYTES > 1) ? $clog2(RESULT_BYTES) : 1;
  localparam int FCNT_W = $clog2(NUM_CORES + 1);
  localparam logic [CORE_W-1:0] LAST_CORE  = CORE_W'(NUM_CORES - 1);
  localparam logic [DCNT_W-1:0] LAST_DBYTE = DCNT_W'(FRAME_BYTES - 1);
  localparam logic [CCNT_W-1:0] LAST_CBYTE = CCNT_W'(RESULT_BYTES - 1);

  typedef enum logic {D_SEL, D_SEND} dstate_e;
  typedef enum logic {C_IDLE, C_FWD} cstate_e;

  dstate_e              dstate_q, dstate_d;
  cstate_e              cstate_q, cstate_d;
  logic [CORE_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CORE_W-1:0]    dsel_q, dsel_d;
  logic [CORE_W-1:0]    csel_q, csel_d;
  logic [DCNT_W-1:0]    dcnt_q, dcnt_d;
  logic [CCNT_W-1:0]    ccnt_q, ccnt_d;
  logic [NUM_CORES-1:0] busy_q, busy_d;
  logic [CORE_W-1:0]    fifo_q [NUM_CORES];
  logic [CORE_W-1:0]    fifo_d [NUM_CORES];
  logic [CORE_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CORE_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]    fcnt_q, fcnt_d;

  logic                 in_xfer;
  logic                 out_xfer;
  logic                 disp_end;
  logic                 coll_end;
  logic                 fifo_pop;
  logic                 free_found;
  logic [CORE_W-1:0]    free_idx;
  logic [CORE_W-1:0]    cand;

  function automatic logic [CORE_W-1:0] wrap_inc(input logic [CORE_W-1:0] v);
    return (v == LAST_CORE) ? '0 : v + CORE_W'(1);
  endfunction

  // First idle core at or above rr_ptr, wrapping; the descending loop lets the nearest win.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    cand       = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      cand = CORE_W'((int'(rr_ptr_q) + i) % NUM_CORES);
      if (!busy_q[cand]) begin
        free_found = 1'b1;
        free_idx   = cand;
      end
    end
  end

  always_comb begin
    in_ready      = 1'b0;
    core_in_valid = '0;
    core_in_data  = '0;
    if (dstate_q == D_SEND) begin
      core_in_data[{dsel_q, 3'b000} +: 8] = in_data;
      core_in_valid[dsel_q]               = in_valid;
      in_ready                            = core_in_ready[dsel_q];
    end
  end

  always_comb begin
    out_data       = '0;
    out_valid      = 1'b0;
    core_out_ready = '0;
    if (cstate_q == C_FWD) begin
      out_data               = core_out_data[{csel_q, 3'b000} +: 8];
      out_valid              = core_out_valid[csel_q];
      core_out_ready[csel_q] = out_ready;
    end
  end

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign disp_end  = in_xfer && (dcnt_q == LAST_DBYTE);
  assign coll_end  = out_xfer && (ccnt_q == LAST_CBYTE);
  assign fifo_pop  = (cstate_q == C_IDLE) && (fcnt_q != '0);
  assign core_busy = busy_q;

  always_comb begin
    dstate_d = dstate_q;
    cstate_d = cstate_q;
    rr_ptr_d = rr_ptr_q;
    dsel_d   = dsel_q;
    csel_d   = csel_q;
    dcnt_d   = dcnt_q;
    ccnt_d   = ccnt_q;
    busy_d   = busy_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;

    case (dstate_q)
      D_SEL: begin
        if (free_found) begin
          dsel_d   = free_idx;
          dcnt_d   = '0;
          dstate_d = D_SEND;
        end
      end
      D_SEND: begin
        if (in_xfer) begin
          dcnt_d = dcnt_q + DCNT_W'(1);
          if (disp_end) begin
            busy_d[dsel_q]   = 1'b1;
            fifo_d[wr_ptr_q] = dsel_q;
            wr_ptr_d         = wrap_inc(wr_ptr_q);
            rr_ptr_d         = wrap_inc(dsel_q);
            dstate_d         = D_SEL;
          end
        end
      end
      default: dstate_d = D_SEL;
    endcase

    // The busy clear below targets a different core than any same-cycle set above.
    case (cstate_q)
      C_IDLE: begin
        if (fifo_pop) begin
          csel_d   = fifo_q[rd_ptr_q];
          rd_ptr_d = wrap_inc(rd_ptr_q);
          ccnt_d   = '0;
          cstate_d = C_FWD;
        end
      end
      C_FWD: begin
        if (out_xfer) begin
          ccnt_d = ccnt_q + CCNT_W'(1);
          if (coll_end) begin
            busy_d[csel_q] = 1'b0;
            cstate_d       = C_IDLE;
          end
        end
      end
      default: cstate_d = C_IDLE;
    endcase

    case ({disp_end, fifo_pop})
      2'b10:   fcnt_d = fcnt_q + FCNT_W'(1);
      2'b01:   fcnt_d = fcnt_q - FCNT_W'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dstate_q <= D_SEL;
      cstate_q <= C_IDLE;
      rr_ptr_q <= '0;
      dsel_q   <= '0;
      csel_q   <= '0;
      dcnt_q   <= '0;
      ccnt_q   <= '0;
      busy_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      for (int i = 0; i < NUM_CORES; i++) fifo_q[i] <= '0;
    end else begin
      dstate_q <= dstate_d;
      cstate_q <= cstate_d;
      rr_ptr_q <= rr_ptr_d;
      dsel_q   <= dsel_d;
      csel_q   <= csel_d;
      dcnt_q   <= dcnt_d;
      ccnt_q   <= ccnt_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
      for (int i = 0; i < NUM_CORES; i++) fifo_q[i] <= fifo_d[i];
    end
  end

`ifdef DISPATCHER_STATS_EN
  logic [15:0] disp_cnt_q, disp_cnt_d;
  logic [15:0] ret_cnt_q, ret_cnt_d;

  always_comb begin
    disp_cnt_d = disp_end ? disp_cnt_q + 16'd1 : disp_cnt_q;
    ret_cnt_d  = coll_end ? ret_cnt_q + 16'd1 : ret_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_cnt_q <= '0;
      ret_cnt_q  <= '0;
    end else begin
      disp_cnt_q <= disp_cnt_d;
      ret_cnt_q  <= ret_cnt_d;
    end
  end

  assign frames_dispatched = disp_cnt_q;
  assign frames_returned   = ret_cnt_q;
`endif

endmodule

// File: tb/tb_helios_decoder_dispatcher.sv
// Random-traffic bench for helios_decoder_dispatcher with behavioural cores and an in-order result scoreboard.
module tb_helios_decoder_dispatcher;
  localparam int NC = 2;
  localparam int FB = 4;
  localparam int RB = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [7:0]      in_data = 8'h00;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [8*NC-1:0] core_in_data;
  logic [NC-1:0]   core_in_valid;
  logic [NC-1:0]   core_in_ready = '0;
  logic [8*NC-1:0] core_out_data = '0;
  logic [NC-1:0]   core_out_valid = '0;
  logic [NC-1:0]   core_out_ready;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [NC-1:0]   core_busy;

  helios_decoder_dispatcher #(.NUM_CORES(NC), .FRAME_BYTES(FB), .RESULT_BYTES(RB)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .core_in_data(core_in_data), .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
    .core_out_data(core_out_data), .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .core_busy(core_busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Stand-in decoding: an order-sensitive digest of the frame, one byte per result index.
  function automatic logic [7:0] res_byte(input logic [8*FB-1:0] f, input int r);
    logic [7:0] s;
    s = 8'(r * 59 + 7);
    for (int i = 0; i < FB; i++) s = (s ^ f[8*i +: 8]) + 8'(i * 13 + r);
    return s;
  endfunction

  function automatic logic [8*FB-1:0] new_frame();
    logic [8*FB-1:0] f;
    for (int i = 0; i < FB; i++) f[8*i +: 8] = 8'($urandom);
    return f;
  endfunction

  // Host and core stand-ins
  logic [8*FB-1:0] h_frame;
  int              h_byte = 0;
  bit              h_xfer = 1'b0;
  int              frames_issued = 0;
  int              frames_target = 0;
  logic [7:0]      exp_q[$];
  int              c_st [NC];
  int              c_rx [NC];
  int              c_tx [NC];
  int              c_dly[NC];
  logic [8*FB-1:0] c_buf[NC];

  // Monitor-side reference state
  logic [NC-1:0]   m_busy = '0;
  logic [NC-1:0]   m_mask;
  int              m_order[$];
  int              m_rr = 0;
  int              m_dcnt = 0;
  int              m_cur = 0;
  int              m_ccnt = 0;
  int              m_returned = 0;
  bit              prev_ov = 1'b0;
  bit              prev_ox = 1'b0;

  function automatic int pick_free();
    for (int i = 0; i < NC; i++)
      if (!m_busy[(m_rr + i) % NC]) return (m_rr + i) % NC;
    return -1;
  endfunction

  initial forever begin
    @(negedge clk);
    if (reset) begin
      m_busy = '0;
      m_order.delete();
      m_rr = 0;
      m_dcnt = 0;
      m_ccnt = 0;
      prev_ov = 1'b0;
      prev_ox = 1'b0;
    end else begin
      chk("core_busy", 32'(core_busy), 32'(m_busy));
      m_mask = (m_order.size() > 0) ? (NC'(1) << m_order[0]) : '0;
      chk("ready_not_head", 32'(core_out_ready & ~m_mask), 32'(0));
      if (prev_ov && !prev_ox) chk("out_valid_hold", 32'(out_valid), 32'(1));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_result", 32'(out_valid), 32'(0));
        else chk("result_byte", 32'(out_data), 32'(exp_q.pop_front()));
        m_ccnt++;
        if (m_ccnt == RB) begin
          m_ccnt = 0;
          m_returned++;
          if (m_order.size() > 0) begin
            m_busy[m_order[0]] = 1'b0;
            void'(m_order.pop_front());
          end
        end
      end
      for (int k = 0; k < NC; k++) begin
        if (core_in_valid[k] && core_in_ready[k]) begin
          if (m_dcnt == 0) begin
            m_cur = pick_free();
            chk("dispatch_core", 32'(k), 32'(m_cur));
          end else begin
            chk("dispatch_same_core", 32'(k), 32'(m_cur));
          end
          m_dcnt++;
          if (m_dcnt == FB) begin
            m_dcnt = 0;
            m_busy[k] = 1'b1;
            m_order.push_back(k);
            m_rr = (k + 1) % NC;
          end
        end
      end
      prev_ov = out_valid;
      prev_ox = out_valid && out_ready;
    end
  end

  task automatic tick();
    @(negedge clk);
    h_xfer = in_valid && in_ready;
    if (h_xfer) begin
      h_byte++;
      if (h_byte == FB) begin
        for (int r = 0; r < RB; r++) exp_q.push_back(res_byte(h_frame, r));
        h_byte = 0;
        frames_issued++;
        h_frame = new_frame();
      end
    end
    for (int k = 0; k < NC; k++) begin
      if (core_in_valid[k] && core_in_ready[k]) begin
        c_buf[k][8*c_rx[k] +: 8] = core_in_data[8*k +: 8];
        c_rx[k]++;
        if (c_rx[k] == FB) begin
          c_rx[k]  = 0;
          c_tx[k]  = 0;
          c_st[k]  = 1;
          c_dly[k] = int'($urandom_range(0, 14));
        end
      end
      if (core_out_valid[k] && core_out_ready[k]) begin
        c_tx[k]++;
        if (c_tx[k] == RB) c_st[k] = 0;
      end
    end
    @(posedge clk);
    #1;
    if (!(in_valid && !h_xfer)) begin
      in_valid = (frames_issued < frames_target) && ($urandom_range(0, 3) != 0);
      in_data  = h_frame[8*h_byte +: 8];
    end
    out_ready = ($urandom_range(0, 3) != 0);
    for (int k = 0; k < NC; k++) begin
      if (c_st[k] == 1) begin
        if (c_dly[k] == 0) c_st[k] = 2;
        else c_dly[k]--;
      end
      core_in_ready[k]        = (c_st[k] == 0) && ($urandom_range(0, 3) != 0);
      core_out_valid[k]       = (c_st[k] == 2);
      core_out_data[8*k +: 8] = (c_st[k] == 2) ? res_byte(c_buf[k], c_tx[k]) : 8'h00;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((frames_issued < frames_target || h_byte != 0 || exp_q.size() != 0) && n < 4000) begin
      tick();
      n++;
    end
    tick();
    chk({name, "_pending"}, 32'(exp_q.size()), 32'(0));
    chk({name, "_frames"}, 32'(frames_issued), 32'(frames_target));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(0));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_out_data"}, 32'(out_data), 32'(0));
    chk({tag, "_core_in_valid"}, 32'(core_in_valid), 32'(0));
    chk({tag, "_core_in_data"}, 32'(core_in_data), 32'(0));
    chk({tag, "_core_out_ready"}, 32'(core_out_ready), 32'(0));
    chk({tag, "_core_busy"}, 32'(core_busy), 32'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int k = 0; k < NC; k++) begin
      c_st[k] = 0; c_rx[k] = 0; c_tx[k] = 0; c_dly[k] = 0; c_buf[k] = '0;
    end
    h_frame = new_frame();
    #2 reset = 1'b1;
    #1 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    frames_target = 40;
    drain("random");
    chk("returned_random", 32'(m_returned), 32'(frames_issued));

    // Leave rr_ptr at 1 so the post-reset frame proves the pointer was cleared.
    if (m_rr == 0) begin
      frames_target = frames_issued + 1;
      drain("align");
    end

    frames_target = frames_issued + 1;
    n = 0;
    while (h_byte < 2 && n < 400) begin
      tick();
      n++;
    end
    chk("partial_bytes", 32'(h_byte), 32'(2));
    in_valid      = 1'b1;
    in_data       = h_frame[8*2 +: 8];
    core_in_ready = '1;
    #2 reset = 1'b1;
    #1 check_all_zero("midframe_reset");

    h_byte = 0;
    h_xfer = 1'b0;
    h_frame = new_frame();
    in_valid = 1'b0;
    core_in_ready = '0;
    core_out_valid = '0;
    for (int k = 0; k < NC; k++) begin
      c_st[k] = 0; c_rx[k] = 0; c_tx[k] = 0;
    end
    frames_target = frames_issued + 1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    n = 0;
    while (core_busy == '0 && n < 400) begin
      tick();
      n++;
    end
    chk("post_reset_core0", 32'(core_busy), 32'(1));
    drain("post_reset");
    chk("returned_total", 32'(m_returned), 32'(frames_issued));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
